// File: rtl/walk_service_fsm.sv
// Traffic/pedestrian walk service controller: main/side lights plus walk phase.
// Define ALL_RED_EN to insert all-red clearance states (RED_A/RED_B) after each yellow.
module walk_service_fsm #(
   parameter int T_BASE = 6,
   parameter int T_YEL  = 2,
   parameter int T_WALK = 4,
   parameter int T_RED  = 1
) (
   input  logic       clk,
   input  logic       Reset_N,
   input  logic       Sec_Tick,
   input  logic       Sensor,
   input  logic       WR,
   output logic [2:0] Main_Light,
   output logic [2:0] Side_Light,
   output logic       Walk,
   output logic       WR_Reset,
   output logic [2:0] State
);

   typedef enum logic [2:0] {
      MAIN_GRN = 3'd0,
      MAIN_YEL = 3'd1,
      SIDE_GRN = 3'd2,
      SIDE_YEL = 3'd3,
      WALK     = 3'd4,
      RED_A    = 3'd5,
      RED_B    = 3'd6
   } state_e;

   localparam logic [2:0] L_R = 3'b100;
   localparam logic [2:0] L_Y = 3'b010;
   localparam logic [2:0] L_G = 3'b001;

   // A zero dwell would never see counter = 1, so it is promoted to one tick.
   function automatic logic [5:0] dwell(input int t);
      return (t <= 0) ? 6'd1 : 6'(t);
   endfunction

   localparam logic [5:0] D_BASE = dwell(T_BASE);
   localparam logic [5:0] D_YEL  = dwell(T_YEL);
   localparam logic [5:0] D_WALK = dwell(T_WALK);
   localparam logic [5:0] D_RED  = dwell(T_RED);

   function automatic logic [5:0] dwell_of(input state_e s);
      case (s)
         MAIN_YEL, SIDE_YEL: return D_YEL;
         WALK:               return D_WALK;
         RED_A, RED_B:       return D_RED;
         default:            return D_BASE;
      endcase
   endfunction

   state_e     state_q, state_d, post_yel;
   logic [5:0] cnt_q, cnt_d;
   logic [2:0] main_q, main_d, side_q, side_d;
   logic       walk_q, walk_d, wrr_q, wrr_d;
   logic       fin;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      // Phase over: last tick of the dwell, or dwell already expired and waiting on a condition.
      fin      = (Sec_Tick && (cnt_q == 6'd1)) || (cnt_q == 6'd0);
      post_yel = WR ? WALK : SIDE_GRN;

      case (state_q)
         MAIN_GRN: if (fin && (Sensor || WR)) state_d = MAIN_YEL;
`ifdef ALL_RED_EN
         MAIN_YEL: if (fin) state_d = RED_A;
         RED_A:    if (fin) state_d = post_yel;
         SIDE_YEL: if (fin) state_d = RED_B;
         RED_B:    if (fin) state_d = MAIN_GRN;
`else
         MAIN_YEL: if (fin) state_d = post_yel;
         SIDE_YEL: if (fin) state_d = MAIN_GRN;
`endif
         SIDE_GRN: if (fin) state_d = SIDE_YEL;
         WALK:     if (fin) state_d = Sensor ? SIDE_GRN : MAIN_GRN;
         default:  state_d = MAIN_GRN;
      endcase

      if (state_d != state_q)
         cnt_d = dwell_of(state_d);
      else if (Sec_Tick && (cnt_q != 6'd0))
         cnt_d = cnt_q - 6'd1;

      // Outputs are decoded from the next state and registered, so they move on the transition edge.
      main_d = L_R;
      side_d = L_R;
      case (state_d)
         MAIN_GRN: main_d = L_G;
         MAIN_YEL: main_d = L_Y;
         SIDE_GRN: side_d = L_G;
         SIDE_YEL: side_d = L_Y;
         default:  ;
      endcase
      walk_d = (state_d == WALK);
      wrr_d  = (state_d == WALK) && (state_q != WALK);
   end

   always_ff @(posedge clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q <= MAIN_GRN;
         cnt_q   <= D_BASE;
         main_q  <= L_G;
         side_q  <= L_R;
         walk_q  <= 1'b0;
         wrr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         main_q  <= main_d;
         side_q  <= side_d;
         walk_q  <= walk_d;
         wrr_q   <= wrr_d;
      end
   end

   assign Main_Light = main_q;
   assign Side_Light = side_q;
   assign Walk       = walk_q;
   assign WR_Reset   = wrr_q;
   assign State      = state_q;

endmodule
